// File: rtl/clock_divider_pkg.sv
// Shared helpers for the clock divider: counter width derivation.
package clock_divider_pkg;

  function automatic int ctr_width(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/clock_divider_if.sv
// Strobe interface: the divider drives div_clk, consumers use it as a clock enable.
interface clock_divider_if;
  logic div_clk;

  modport master (output div_clk);
  modport slave  (input  div_clk);
endinterface

// File: rtl/clock_divider_mod_counter.sv
// Modulo-MOD up-counter; wrap_o flags the edge on which the count returns to 0.
module clock_divider_mod_counter
  import clock_divider_pkg::*;
#(
  parameter int MOD = 2
) (
  input  logic clk,
  input  logic rst,
  output logic wrap_o
);

  localparam int               CTR_W = ctr_width(MOD);
  localparam logic [CTR_W-1:0] LAST  = CTR_W'(MOD - 1);

  logic [CTR_W-1:0] ctr_q;
  logic [CTR_W-1:0] ctr_d;

  assign wrap_o = (ctr_q == LAST);

  always_comb begin
    ctr_d = ctr_q + CTR_W'(1);
    if (wrap_o) ctr_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) ctr_q <= '0;
    else     ctr_q <= ctr_d;
  end

endmodule

// File: rtl/clock_divider.sv
// Integer clock divider: one-cycle registered strobe every DIV clk cycles.
module clock_divider
  import clock_divider_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic            clk,
  input  logic            rst,
  clock_divider_if.master div_if
);

  generate
    if (DIV < 1) begin : g_bad_div
      $error("clock_divider: DIV must be >= 1");
    end
  endgenerate

  logic wrap;
  logic div_clk_q;
  logic div_clk_d;

  clock_divider_mod_counter #(
    .MOD (DIV)
  ) u_ctr (
    .clk    (clk),
    .rst    (rst),
    .wrap_o (wrap)
  );

  // Registering the wrap puts the strobe after edges DIV, 2*DIV, ...
  assign div_clk_d = wrap;

  always_ff @(posedge clk) begin
    if (rst) div_clk_q <= 1'b0;
    else     div_clk_q <= div_clk_d;
  end

  assign div_if.div_clk = div_clk_q;

endmodule

// File: tb/tb_clock_divider.sv
// Scoreboard bench: four dividers (DIV=1,2,3,500) sharing clk/rst.
module tb_clock_divider;

  logic clk = 1'b0;
  logic rst = 1'b1;

  clock_divider_if if_d1 ();
  clock_divider_if if_d2 ();
  clock_divider_if if_d3 ();
  clock_divider_if if_d500 ();

  clock_divider #(.DIV(1))   u_d1   (.clk(clk), .rst(rst), .div_if(if_d1.master));
  clock_divider #(.DIV(2))   u_d2   (.clk(clk), .rst(rst), .div_if(if_d2.master));
  clock_divider #(.DIV(3))   u_d3   (.clk(clk), .rst(rst), .div_if(if_d3.master));
  clock_divider #(.DIV(500)) u_d500 (.clk(clk), .rst(rst), .div_if(if_d500.master));

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] exp;
    bit         win12;
    bit         win5000;
    int         edge_no;
  } exp_t;

  exp_t exp_q[$];

  int n_vec     = 0;
  int n_bad     = 0;
  int pulses3   = 0;
  int pulses500 = 0;
  int k         = 0;
  bit in_run    = 1'b0;

  // Edge k after release carries a pulse for ratio d exactly when d divides k.
  function automatic logic [3:0] model(input int kk);
    logic [3:0] m;
    m[0] = (kk > 0) && (kk % 1 == 0);
    m[1] = (kk > 0) && (kk % 2 == 0);
    m[2] = (kk > 0) && (kk % 3 == 0);
    m[3] = (kk > 0) && (kk % 500 == 0);
    return m;
  endfunction

  task automatic step(input logic r, input bit glitch = 1'b0);
    exp_t e;
    rst = r;
    if (glitch) begin
      #2 rst = 1'b1;
      #2 rst = r;
    end
    @(posedge clk);
    #1;
    if (r) k = 0;
    else   k = k + 1;
    e.exp     = model(k);
    e.win5000 = in_run && !r;
    e.win12   = in_run && !r && (k <= 12);
    e.edge_no = k;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
  endtask

  initial begin : monitor
    exp_t       e;
    logic [3:0] act;
    int         divs [4];
    divs = '{1, 2, 3, 500};
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e   = exp_q.pop_front();
        act = {if_d500.div_clk, if_d3.div_clk, if_d2.div_clk, if_d1.div_clk};
        for (int i = 0; i < 4; i++) begin
          n_vec++;
          if (act[i] !== e.exp[i]) begin
            n_bad++;
            $display("FAIL div%0d edge %0d: div_clk=%b expected %b",
                     divs[i], e.edge_no, act[i], e.exp[i]);
          end
        end
        if (e.win12 && act[2] === 1'b1) pulses3++;
        if (e.win5000 && act[3] === 1'b1) pulses500++;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    rst = 1'b1;
    step(1'b1);
    step(1'b1);

    in_run = 1'b1;
    for (int i = 0; i < 5000; i++) step(1'b0, (i == 1234));
    in_run = 1'b0;
    drain();

    n_vec++;
    if (pulses500 != 10) begin
      n_bad++;
      $display("FAIL pulses500: counted %0d expected 10", pulses500);
    end
    n_vec++;
    if (pulses3 != 4) begin
      n_bad++;
      $display("FAIL pulses3_first12: counted %0d expected 4", pulses3);
    end

    // Reset on the edge right after a DIV=3 pulse.
    while (k % 3 != 0) step(1'b0);
    step(1'b1);
    for (int i = 0; i < 10; i++) step(1'b0);

    // Two-cycle reset in mid-period.
    for (int i = 0; i < 4; i++) step(1'b0);
    step(1'b1);
    step(1'b1);
    for (int i = 0; i < 8; i++) step(1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
